// File: rtl/kbd_fifo_ctrl.sv
// Keyboard event controller: turns scanner levels into key events with typematic
// auto-repeat, queues them in a small FIFO and exposes DATA/STATUS/CTRL registers.
module kbd_fifo_ctrl #(
    parameter int DEPTH         = 4,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_code,
    input  logic        key_pressed,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        irq
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = PW + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t          state_reg;
    logic [TW-1:0]   cnt_reg;
    logic [3:0]      held_code_reg;
    logic            prev_pressed_reg;
    logic            block_reg;
    logic            enable_reg;
    logic            repeat_en_reg;
    logic            irq_en_reg;
    logic            overflow_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [3:0]      mem [DEPTH];

    logic            new_press;
    logic            code_change;
    logic            push;
    logic [3:0]      push_code;
    logic            ctrl_wr;
    logic            flush;
    logic            do_pop;
    logic            full;
    logic            fifo_we;
    logic            overflow_set;
    logic            wdata_unused;

    assign wdata_unused = ^wdata[15:5];

    // block_reg masks a key that was already down during reset until it is released.
    assign new_press   = key_pressed & ~prev_pressed_reg & ~block_reg;
    assign code_change = key_pressed & (key_code != held_code_reg);

    always_comb begin
        push      = 1'b0;
        push_code = key_code;
        if (enable_reg) begin
            case (state_reg)
                ST_IDLE: push = new_press;
                ST_DELAY: begin
                    if (code_change) begin
                        push = 1'b1;
                    end else if (key_pressed && repeat_en_reg && cnt_reg >= DELAY_LAST) begin
                        push      = 1'b1;
                        push_code = held_code_reg;
                    end
                end
                ST_REPEAT: begin
                    if (code_change) begin
                        push = 1'b1;
                    end else if (key_pressed && repeat_en_reg && cnt_reg == PERIOD_LAST) begin
                        push      = 1'b1;
                        push_code = held_code_reg;
                    end
                end
                default: push = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_pressed_reg <= 1'b0;
            block_reg        <= key_pressed;
        end else begin
            prev_pressed_reg <= key_pressed;
            if (!key_pressed) begin
                block_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            held_code_reg <= 4'h0;
        end else if (!enable_reg) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            if (push) begin
                held_code_reg <= push_code;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (new_press) begin
                        state_reg <= ST_DELAY;
                        cnt_reg   <= '0;
                    end
                end
                ST_DELAY: begin
                    if (!key_pressed) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else if (code_change) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg >= DELAY_LAST) begin
                        // Without repeat enabled the counter parks here until it is.
                        if (repeat_en_reg) begin
                            state_reg <= ST_REPEAT;
                            cnt_reg   <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + TW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!key_pressed) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else if (code_change) begin
                        state_reg <= ST_DELAY;
                        cnt_reg   <= '0;
                    end else if (!repeat_en_reg) begin
                        state_reg <= ST_DELAY;
                    end else if (cnt_reg == PERIOD_LAST) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + TW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign ctrl_wr = cs & wr & (addr == 2'd2);
    assign flush   = ctrl_wr & wdata[3];
    assign do_pop  = cs & rd & (addr == 2'd0) & (count_reg != '0);
    assign full    = (count_reg == FULL_COUNT);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign fifo_we      = push & ~flush & (~full | do_pop);
    assign overflow_set = push & ~flush & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (fifo_we) begin
            mem[wr_ptr_reg] <= push_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            enable_reg    <= 1'b1;
            repeat_en_reg <= 1'b0;
            irq_en_reg    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable_reg    <= wdata[0];
                repeat_en_reg <= wdata[1];
                irq_en_reg    <= wdata[2];
            end
            if (flush) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (fifo_we) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
                if (fifo_we && !do_pop) begin
                    count_reg <= count_reg + CW'(1);
                end else if (!fifo_we && do_pop) begin
                    count_reg <= count_reg - CW'(1);
                end
                if (overflow_set) begin
                    overflow_reg <= 1'b1;
                end else if (ctrl_wr && wdata[4]) begin
                    overflow_reg <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (cs && rd) begin
            case (addr)
                2'd0: begin
                    if (count_reg != '0) begin
                        rdata = {1'b1, 11'b0, mem[rd_ptr_reg]};
                    end
                end
                2'd1: rdata = 16'({irq_en_reg, repeat_en_reg, enable_reg, overflow_reg, count_reg});
                2'd2: rdata = {13'b0, irq_en_reg, repeat_en_reg, enable_reg};
                default: rdata = 16'h0000;
            endcase
        end
    end

    assign irq = irq_en_reg & (count_reg != '0);

endmodule

// File: tb/tb_kbd_fifo_ctrl.sv
// Directed bench for kbd_fifo_ctrl with a queue/timestamp reference model checked
// every cycle, plus hand-computed register values for each scenario.
module tb_kbd_fifo_ctrl;

    localparam int DEPTH = 4;
    localparam int RD    = 20;
    localparam int RP    = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_code;
    logic        key_pressed;
    logic        cs, rd, wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    always #5 clk = ~clk;

    kbd_fifo_ctrl #(.DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_pressed(key_pressed),
        .cs(cs), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irq(irq)
    );

    // Reference model: queue of codes, and key timing tracked as timestamps.
    logic [3:0] mq[$];
    bit         m_en, m_rep, m_irqen, m_ovf, m_prev, m_block, m_track, m_first;
    logic [3:0] m_code;
    int         m_last;
    int         cyc = 0;
    int         ev_log[$];

    always @(posedge clk) begin
        automatic bit         ev = 1'b0;
        automatic logic [3:0] evc = key_code;
        automatic bit         newp;
        automatic bit         cw;
        automatic bit         pop;
        if (rst) begin
            mq.delete();
            m_en = 1'b1; m_rep = 1'b0; m_irqen = 1'b0; m_ovf = 1'b0;
            m_prev = 1'b0; m_block = key_pressed; m_track = 1'b0; m_code = 4'h0;
        end else begin
            newp = key_pressed && !m_prev && !m_block;
            if (!m_en) begin
                m_track = 1'b0;
            end else if (!m_track) begin
                if (newp) begin
                    ev = 1'b1; m_track = 1'b1; m_first = 1'b1; m_last = cyc;
                end
            end else if (!key_pressed) begin
                m_track = 1'b0;
            end else if (key_code != m_code) begin
                ev = 1'b1; m_first = 1'b1; m_last = cyc;
            end else if (m_first) begin
                if (m_rep && (cyc - m_last) >= RD) begin
                    ev = 1'b1; evc = m_code; m_first = 1'b0; m_last = cyc;
                end
            end else if (!m_rep) begin
                m_first = 1'b1; m_last = m_last + 1;
            end else if ((cyc - m_last) == RP) begin
                ev = 1'b1; evc = m_code; m_last = cyc;
            end
            if (ev) begin
                m_code = evc;
                ev_log.push_back(cyc);
            end
            cw  = cs && wr && (addr == 2'd2);
            pop = cs && rd && (addr == 2'd0) && (mq.size() > 0);
            if (cw && wdata[3]) begin
                mq.delete();
                m_ovf = 1'b0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (cw && wdata[4]) m_ovf = 1'b0;
                if (ev) begin
                    if (mq.size() < DEPTH) mq.push_back(evc);
                    else m_ovf = 1'b1;
                end
            end
            if (cw) begin
                m_en = wdata[0]; m_rep = wdata[1]; m_irqen = wdata[2];
            end
            m_prev = key_pressed;
            if (!key_pressed) m_block = 1'b0;
        end
        cyc++;
    end

    function automatic logic [15:0] exp_rdata();
        logic [15:0] r;
        r = 16'h0000;
        if (cs && rd) begin
            case (addr)
                2'd0: if (mq.size() > 0) r = {1'b1, 11'b0, mq[0]};
                2'd1: r = {9'b0, m_irqen, m_rep, m_en, m_ovf, 3'(mq.size())};
                2'd2: r = {13'b0, m_irqen, m_rep, m_en};
                default: r = 16'h0000;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (run && !rst) begin
            chk("rdata_vs_model", rdata, exp_rdata());
            chk("irq_vs_model", {15'b0, irq}, {15'b0, (m_irqen && mq.size() > 0)});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_reg(input logic [1:0] a, input logic [15:0] exp, input string name);
        cs = 1'b1; rd = 1'b1; addr = a;
        #2;
        $display("read  addr=%0d rdata=%h expect=%h (%s)", a, rdata, exp, name);
        chk(name, rdata, exp);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; addr = 2'd0;
    endtask

    task automatic write_ctrl(input logic [15:0] v);
        cs = 1'b1; wr = 1'b1; addr = 2'd2; wdata = v;
        $display("write CTRL=%h", v);
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 16'h0;
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int gap);
        key_code = code; key_pressed = 1'b1;
        tick(hold);
        key_pressed = 1'b0;
        tick(gap);
    endtask

    task automatic chk_irq(input logic exp, input string name);
        #2;
        chk(name, {15'b0, irq}, {15'b0, exp});
    endtask

    initial begin
        automatic int offs[5] = '{0, 20, 25, 30, 35};
        rst = 1'b1; key_code = 4'h0; key_pressed = 1'b0;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 16'h0;
        tick(3);
        rst = 1'b0;
        run = 1'b1;

        // Reset state
        chk_irq(1'b0, "reset_irq");
        tick(1);
        read_reg(2'd1, 16'h0010, "reset_status");
        read_reg(2'd2, 16'h0001, "reset_ctrl");
        read_reg(2'd0, 16'h0000, "reset_data_empty");

        // Single press of 0x7
        key_code = 4'h7; key_pressed = 1'b1;
        tick(1);
        read_reg(2'd1, 16'h0011, "single_count_after_edge1");
        tick(8);
        key_pressed = 1'b0;
        tick(2);
        read_reg(2'd0, 16'h8007, "single_data");
        read_reg(2'd1, 16'h0010, "single_count_zero");
        read_reg(2'd0, 16'h0000, "single_data_empty");

        // Overflow with five distinct presses
        for (int i = 1; i <= 5; i++) press(4'(i), 2, 2);
        read_reg(2'd1, 16'h001C, "ovf_status");
        for (int i = 1; i <= 4; i++) read_reg(2'd0, 16'h8000 | 16'(i), "ovf_data_order");
        write_ctrl(16'h0017);
        read_reg(2'd1, 16'h0070, "ovf_cleared_status");

        // Auto-repeat of 0xA held for 40 cycles
        write_ctrl(16'h0003);
        ev_log.delete();
        press(4'hA, 40, 2);
        chk("repeat_model_events", 16'(ev_log.size()), 16'd5);
        for (int i = 0; i < 5 && i < ev_log.size(); i++)
            chk("repeat_model_offset", 16'(ev_log[i] - ev_log[0]), 16'(offs[i]));
        read_reg(2'd1, 16'h003C, "repeat_status");
        for (int i = 0; i < 4; i++) read_reg(2'd0, 16'h800A, "repeat_data");
        read_reg(2'd0, 16'h0000, "repeat_data_empty");
        write_ctrl(16'h0011);

        // Push and pop in the same cycle at full
        for (int i = 1; i <= 4; i++) press(4'(i), 2, 2);
        key_code = 4'hC; key_pressed = 1'b1;
        read_reg(2'd0, 16'h8001, "pushpop_head");
        key_pressed = 1'b0;
        tick(1);
        read_reg(2'd1, 16'h0014, "pushpop_status");
        read_reg(2'd0, 16'h8002, "pushpop_d1");
        read_reg(2'd0, 16'h8003, "pushpop_d2");
        read_reg(2'd0, 16'h8004, "pushpop_d3");
        read_reg(2'd0, 16'h800C, "pushpop_last");

        // Flush colliding with a new press
        press(4'h5, 2, 2);
        key_code = 4'h6; key_pressed = 1'b1;
        write_ctrl(16'h000F);
        key_pressed = 1'b0;
        tick(2);
        read_reg(2'd1, 16'h0070, "flush_status");
        write_ctrl(16'h0005);

        // Interrupt rise and fall
        key_code = 4'h3; key_pressed = 1'b1;
        chk_irq(1'b0, "irq_before_edge");
        tick(1);
        chk_irq(1'b1, "irq_after_press");
        tick(1);
        key_pressed = 1'b0;
        tick(1);
        read_reg(2'd0, 16'h8003, "irq_data");
        chk_irq(1'b0, "irq_after_pop");
        tick(1);

        // Disabled: press is ignored
        write_ctrl(16'h0004);
        press(4'h9, 3, 2);
        read_reg(2'd1, 16'h0040, "disabled_status");
        chk_irq(1'b0, "disabled_irq");
        tick(1);

        // Re-enable while the key is held
        key_code = 4'h9; key_pressed = 1'b1;
        tick(2);
        write_ctrl(16'h0005);
        tick(3);
        key_pressed = 1'b0;
        tick(2);
        read_reg(2'd1, 16'h0050, "reenable_held_status");

        // Reset while a key is held, then a fresh press
        key_code = 4'hE; key_pressed = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        read_reg(2'd1, 16'h0010, "reset_held_status");
        key_pressed = 1'b0;
        tick(2);
        press(4'hE, 3, 1);
        read_reg(2'd1, 16'h0011, "repress_status");
        read_reg(2'd0, 16'h800E, "repress_data");
        read_reg(2'd1, 16'h0010, "repress_empty");

        tick(2);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
